// File: rtl/stage4_memory_access.sv
// Memory-access stage: issues loads/stores over a req/ready handshake and registers stage-5 writeback controls.
// Optional macro STAGE4_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into a non-writing fault flag.

`ifndef RANGE_INSTRS
`define RANGE_INSTRS 7:0
`endif
`ifndef DO_LOAD
`define DO_LOAD 0
`endif
`ifndef DO_STORE
`define DO_STORE 1
`endif
`ifndef DO_BRANCH
`define DO_BRANCH 2
`endif
`ifndef DO_JAL
`define DO_JAL 3
`endif
`ifndef DO_JALR
`define DO_JALR 4
`endif

module stage4_memory_access (
    input  logic                 clock,
    input  logic                 reset_n,

    input  logic                 in_valid,
    input  logic                 in_flush,
    input  logic [`RANGE_INSTRS] in_instr_type,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic [31:0]          in_alu_output,
    input  logic [31:0]          in_store_data,
    input  logic [31:0]          in_ia_plus4,

    output logic                 stall_out,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,

    output logic                 wb_valid,
    output logic [`RANGE_INSTRS] instr_type,
    output logic [2:0]           load_type,
    output logic                 sign_extend,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [31:0]          ia_plus4,
    output logic [31:0]          alu_output,
    output logic [31:0]          memory_read_value
`ifdef STAGE4_MISALIGN_TRAP_EN
    ,
    output logic                 misaligned
`endif
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_killed;

    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_issue;
    logic        w_kill_now;
    logic [1:0]  w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
`ifdef STAGE4_MISALIGN_TRAP_EN
    logic        w_misaligned;
`endif

    assign stall_out = (r_state == S_ACCESS);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_accept   = in_valid && !in_flush && (r_state == S_IDLE);
        w_is_load  = in_instr_type[`DO_LOAD];
        w_is_store = in_instr_type[`DO_STORE];
        w_kill_now = r_killed || in_flush;
        w_offset   = 2'b00;
        w_be       = 4'b1111;
        w_wdata    = in_store_data;
`ifdef STAGE4_MISALIGN_TRAP_EN
        w_misaligned = 1'b0;
`endif

        // Low address bits are snapped to the access size before lane selection.
        case (in_funct3[1:0])
            2'b00: begin
                w_offset = in_alu_output[1:0];
                w_wdata  = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                w_offset = {in_alu_output[1], 1'b0};
                w_wdata  = {2{in_store_data[15:0]}};
`ifdef STAGE4_MISALIGN_TRAP_EN
                w_misaligned = (w_is_load || w_is_store) && in_alu_output[0];
`endif
            end
            default: begin
                w_offset = 2'b00;
                w_wdata  = in_store_data;
`ifdef STAGE4_MISALIGN_TRAP_EN
                w_misaligned = (w_is_load || w_is_store) && (in_alu_output[1:0] != 2'b00);
`endif
            end
        endcase

        if (w_is_store) begin
            case (in_funct3[1:0])
                2'b00:   w_be = 4'b0001 << w_offset;
                2'b01:   w_be = 4'b0011 << w_offset;
                default: w_be = 4'b1111;
            endcase
        end

`ifdef STAGE4_MISALIGN_TRAP_EN
        w_issue = (w_is_load || w_is_store) && !w_misaligned;
`else
        w_issue = w_is_load || w_is_store;
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_killed          <= 1'b0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            mem_be            <= '0;
            wb_valid          <= 1'b0;
            instr_type        <= '0;
            load_type         <= '0;
            sign_extend       <= 1'b0;
            rs1               <= '0;
            rs2               <= '0;
            rd                <= '0;
            ia_plus4          <= '0;
            alu_output        <= '0;
            memory_read_value <= '0;
`ifdef STAGE4_MISALIGN_TRAP_EN
            misaligned        <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        instr_type  <= in_instr_type;
                        load_type   <= in_funct3;
                        sign_extend <= ~in_funct3[2];
                        rs1         <= in_rs1;
                        rs2         <= in_rs2;
                        rd          <= in_rd;
                        ia_plus4    <= in_ia_plus4;
                        alu_output  <= in_alu_output;
                        r_killed    <= 1'b0;
`ifdef STAGE4_MISALIGN_TRAP_EN
                        misaligned  <= w_misaligned;
`endif
                        if (w_issue) begin
                            r_state   <= S_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= w_is_store;
                            mem_addr  <= {in_alu_output[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end else begin
                            wb_valid  <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (in_flush) begin
                        r_killed <= 1'b1;
                    end
                    // A killed access still completes so a store is never torn.
                    if (mem_ready) begin
                        if (instr_type[`DO_LOAD] && !w_kill_now) begin
                            memory_read_value <= mem_rdata;
                        end
                        wb_valid <= !w_kill_now;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'b0000;
                        r_killed <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage4_memory_access.sv
// Bench for stage4_memory_access: directed scenarios plus randomized instructions against a size/lane reference model.
// Works with or without STAGE4_MISALIGN_TRAP_EN defined.

module tb_stage4_memory_access;

    localparam int B_LOAD   = 0;
    localparam int B_STORE  = 1;
    localparam int B_BRANCH = 2;
    localparam int B_JAL    = 3;
    localparam int B_JALR   = 4;
    localparam int B_ALU    = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_flush = 1'b0;
    logic [7:0]  in_instr_type = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu_output = '0;
    logic [31:0] in_store_data = '0;
    logic [31:0] in_ia_plus4 = '0;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [7:0]  instr_type;
    logic [2:0]  load_type;
    logic        sign_extend;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] ia_plus4;
    logic [31:0] alu_output;
    logic [31:0] memory_read_value;
`ifdef STAGE4_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    stage4_memory_access dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_flush          (in_flush),
        .in_instr_type     (in_instr_type),
        .in_funct3         (in_funct3),
        .in_rs1            (in_rs1),
        .in_rs2            (in_rs2),
        .in_rd             (in_rd),
        .in_alu_output     (in_alu_output),
        .in_store_data     (in_store_data),
        .in_ia_plus4       (in_ia_plus4),
        .stall_out         (stall_out),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .wb_valid          (wb_valid),
        .instr_type        (instr_type),
        .load_type         (load_type),
        .sign_extend       (sign_extend),
        .rs1               (rs1),
        .rs2               (rs2),
        .rd                (rd),
        .ia_plus4          (ia_plus4),
        .alu_output        (alu_output),
        .memory_read_value (memory_read_value)
`ifdef STAGE4_MISALIGN_TRAP_EN
        ,
        .misaligned        (misaligned)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr, input bit is_store);
        int sz;
        int off;
        if (!is_store) return 4'hF;
        sz  = size_of(f3);
        off = (int'(addr[1:0]) / sz) * sz;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % sz) +: 8];
        return w;
    endfunction

`ifdef STAGE4_MISALIGN_TRAP_EN
    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % size_of(f3)) != 0;
    endfunction
`endif

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int cls_bit, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rdv, input logic [31:0] ia);
        in_valid      = 1'b1;
        in_flush      = 1'b0;
        in_instr_type = 8'(1 << cls_bit);
        in_funct3     = f3;
        in_alu_output = addr;
        in_store_data = data;
        in_rs1        = r1;
        in_rs2        = r2;
        in_rd         = rdv;
        in_ia_plus4   = ia;
    endtask

    task automatic scramble();
        in_valid      = 1'($urandom);
        in_instr_type = 8'($urandom);
        in_funct3     = 3'($urandom);
        in_alu_output = $urandom;
        in_store_data = $urandom;
        in_rs1        = 5'($urandom);
        in_rs2        = 5'($urandom);
        in_rd         = 5'($urandom);
        in_ia_plus4   = $urandom;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        tests_run++;
        if ({stall_out, mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, instr_type, load_type,
             sign_extend, rs1, rs2, rd, ia_plus4, alu_output, memory_read_value} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req=%b we=%b be=%h wb=%b stall=%b rd=%h alu=%h mrv=%h, all must be 0",
                     mem_req, mem_we, mem_be, wb_valid, stall_out, rd, alu_output, memory_read_value);
        end
`ifdef STAGE4_MISALIGN_TRAP_EN
        tests_run++;
        if (misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_misaligned: got %b expected 0", misaligned);
        end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        drive(B_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd1, 5'd2, 5'd5, 32'h0000_0404);
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({wb_valid, alu_output, rd, mem_req, stall_out} !== {1'b1, 32'h1234, 5'd5, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_result: wb=%b alu=%h rd=%0d req=%b stall=%b, expected wb=1 alu=1234 rd=5 req=0 stall=0",
                     wb_valid, alu_output, rd, mem_req, stall_out);
        end
        step();
        tests_run++;
        if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_pulse: wb_valid got %b expected 0", wb_valid);
        end
    endtask

    task automatic test_load_delayed();
        drive(B_LOAD, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 5'd4, 5'd7, 32'h0000_0808);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({mem_req, mem_we, mem_addr, mem_be, stall_out, wb_valid} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL lw_wait cycle %0d: req=%b we=%b addr=%h be=%h stall=%b wb=%b, expected 1 0 100 f 1 0",
                         k, mem_req, mem_we, mem_addr, mem_be, stall_out, wb_valid);
            end
            if (k == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        mem_ready = 1'b0;
        tests_run++;
        if ({wb_valid, memory_read_value, sign_extend, stall_out, mem_req, rd, load_type} !==
            {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd7, 3'b010}) begin
            tests_failed++;
            $display("FAIL lw_done: wb=%b mrv=%h sx=%b stall=%b req=%b rd=%0d lt=%b, expected 1 deadbeef 1 0 0 7 010",
                     wb_valid, memory_read_value, sign_extend, stall_out, mem_req, rd, load_type);
        end
    endtask

    task automatic test_store_byte();
        drive(B_STORE, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5'd8, 5'd9, 5'd0, 32'h0);
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h200}) begin
            tests_failed++;
            $display("FAIL sb_request: req=%b we=%b be=%b wdata=%h addr=%h, expected 1 1 1000 a5a5a5a5 200",
                     mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        tests_run++;
        if ({wb_valid, stall_out, mem_req} !== 3'b100) begin
            tests_failed++;
            $display("FAIL sb_done: wb=%b stall=%b req=%b, expected 1 0 0", wb_valid, stall_out, mem_req);
        end
    endtask

    task automatic test_flush();
        // Flush in IDLE makes the input a bubble.
        drive(B_ALU, 3'b000, 32'h0000_0077, 32'h0, 5'd1, 5'd1, 5'd12, 32'h0);
        in_flush = 1'b1;
        step();
        in_valid = 1'b0;
        in_flush = 1'b0;
        tests_run++;
        if ({wb_valid, stall_out} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_idle: wb=%b stall=%b, expected 0 0", wb_valid, stall_out);
        end
        // Flush during ACCESS lets the access finish silently.
        drive(B_LOAD, 3'b101, 32'h0000_0102, 32'h0, 5'd2, 5'd2, 5'd6, 32'h0);
        step();
        in_valid = 1'b0;
        in_flush = 1'b1;
        tests_run++;
        if ({mem_req, stall_out, mem_addr} !== {1'b1, 1'b1, 32'h100}) begin
            tests_failed++;
            $display("FAIL lhu_request: req=%b stall=%b addr=%h, expected 1 1 100", mem_req, stall_out, mem_addr);
        end
        step();
        in_flush = 1'b0;
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL lhu_flush_hold: mem_req got %b expected 1", mem_req);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        mem_ready = 1'b0;
        tests_run++;
        if ({wb_valid, stall_out, mem_req} !== 3'b000) begin
            tests_failed++;
            $display("FAIL lhu_killed: wb=%b stall=%b req=%b, expected 0 0 0", wb_valid, stall_out, mem_req);
        end
        drive(B_ALU, 3'b000, 32'h0000_0055, 32'h0, 5'd1, 5'd1, 5'd9, 32'h0);
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({wb_valid, rd, alu_output} !== {1'b1, 5'd9, 32'h55}) begin
            tests_failed++;
            $display("FAIL add_after_flush: wb=%b rd=%0d alu=%h, expected 1 9 55", wb_valid, rd, alu_output);
        end
    endtask

    task automatic test_reset_during_access();
        drive(B_LOAD, 3'b010, 32'h0000_0040, 32'h0, 5'd1, 5'd1, 5'd4, 32'h0);
        step();
        in_valid = 1'b0;
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_access_req: mem_req got %b expected 1", mem_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, stall_out, wb_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_async: req=%b stall=%b wb=%b, expected 0 0 0", mem_req, stall_out, wb_valid);
        end
        step();
        reset_n = 1'b1;
        drive(B_ALU, 3'b000, 32'h0000_0099, 32'h0, 5'd1, 5'd1, 5'd10, 32'h0);
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({wb_valid, rd, mem_req} !== {1'b1, 5'd10, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_after_reset: wb=%b rd=%0d req=%b, expected 1 10 0", wb_valid, rd, mem_req);
        end
    endtask

    task automatic test_misaligned_word();
        drive(B_LOAD, 3'b010, 32'h0000_0102, 32'h0, 5'd1, 5'd1, 5'd3, 32'h0);
        step();
        in_valid = 1'b0;
`ifdef STAGE4_MISALIGN_TRAP_EN
        tests_run++;
        if ({mem_req, wb_valid, misaligned, stall_out} !== 4'b0110) begin
            tests_failed++;
            $display("FAIL lw_trap: req=%b wb=%b mis=%b stall=%b, expected 0 1 1 0", mem_req, wb_valid, misaligned, stall_out);
        end
`else
        tests_run++;
        if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'hF}) begin
            tests_failed++;
            $display("FAIL lw_aligned_addr: req=%b addr=%h be=%h, expected 1 100 f", mem_req, mem_addr, mem_be);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ready = 1'b0;
        tests_run++;
        if ({wb_valid, memory_read_value} !== {1'b1, 32'h0BAD_F00D}) begin
            tests_failed++;
            $display("FAIL lw_aligned_done: wb=%b mrv=%h, expected 1 0badf00d", wb_valid, memory_read_value);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        drive(B_LOAD, 3'b010, 32'h0000_0A00, 32'h0, 5'd1, 5'd1, 5'd17, 32'h0);
        step();
        drive(B_LOAD, 3'b010, 32'h0000_0B04, 32'h0, 5'd2, 5'd2, 5'd18, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hA00}) begin
            tests_failed++;
            $display("FAIL b2b_first_req: req=%b addr=%h, expected 1 a00", mem_req, mem_addr);
        end
        step();
        mem_rdata = 32'hCCCC_0003;
        tests_run++;
        if ({wb_valid, memory_read_value, rd, mem_req, stall_out} !== {1'b1, 32'hAAAA_0001, 5'd17, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_first_done: wb=%b mrv=%h rd=%0d req=%b stall=%b, expected 1 aaaa0001 17 0 0",
                     wb_valid, memory_read_value, rd, mem_req, stall_out);
        end
        step();
        in_valid = 1'b0;
        mem_rdata = 32'hBBBB_0002;
        tests_run++;
        if ({mem_req, mem_addr, stall_out, wb_valid, memory_read_value} !== {1'b1, 32'hB04, 1'b1, 1'b0, 32'hAAAA_0001}) begin
            tests_failed++;
            $display("FAIL b2b_second_req: req=%b addr=%h stall=%b wb=%b mrv=%h, expected 1 b04 1 0 aaaa0001",
                     mem_req, mem_addr, stall_out, wb_valid, memory_read_value);
        end
        step();
        mem_ready = 1'b0;
        tests_run++;
        if ({wb_valid, memory_read_value, rd} !== {1'b1, 32'hBBBB_0002, 5'd18}) begin
            tests_failed++;
            $display("FAIL b2b_second_done: wb=%b mrv=%h rd=%0d, expected 1 bbbb0002 18",
                     wb_valid, memory_read_value, rd);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          cls;
            int          delay;
            int          kill_at;
            bit          is_load;
            bit          is_store;
            bit          trap;
            bit          issue;
            bit          kill;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [31:0] data;
            logic [31:0] ia;
            logic [31:0] rdata;
            logic [4:0]  r1;
            logic [4:0]  r2;
            logic [4:0]  rdv;

            // Idle gap: bubbles and stray mem_ready must not produce anything.
            scramble();
            in_flush  = 1'($urandom);
            if (!in_flush) in_valid = 1'b0;
            mem_ready = 1'($urandom);
            step();
            tests_run++;
            if ({wb_valid, mem_req, stall_out} !== 3'b000) begin
                tests_failed++;
                $display("FAIL rand_gap %0d: wb=%b req=%b stall=%b, expected 0 0 0", n, wb_valid, mem_req, stall_out);
            end

            cls  = $urandom_range(0, 5);
            addr = $urandom;
            data = $urandom;
            ia   = $urandom;
            r1   = 5'($urandom);
            r2   = 5'($urandom);
            rdv  = 5'($urandom);
            case (cls)
                0, 1: begin
                    cls = B_LOAD;
                    case ($urandom_range(0, 4))
                        0:       f3 = 3'b000;
                        1:       f3 = 3'b001;
                        2:       f3 = 3'b010;
                        3:       f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
                2: begin
                    cls = B_STORE;
                    f3  = 3'($urandom_range(0, 2));
                end
                3:       begin cls = B_ALU;    f3 = 3'($urandom); end
                4:       begin cls = B_BRANCH; f3 = 3'($urandom); end
                default: begin cls = ($urandom_range(0, 1) == 0) ? B_JAL : B_JALR; f3 = 3'($urandom); end
            endcase
            is_load  = (cls == B_LOAD);
            is_store = (cls == B_STORE);
`ifdef STAGE4_MISALIGN_TRAP_EN
            trap = (is_load || is_store) && model_misaligned(f3, addr);
`else
            trap = 1'b0;
`endif
            issue = (is_load || is_store) && !trap;

            drive(cls, f3, addr, data, r1, r2, rdv, ia);
            mem_ready = 1'($urandom);
            step();

            if (!issue) begin
                in_valid  = 1'b0;
                mem_ready = 1'b0;
                tests_run++;
                if ({wb_valid, mem_req, stall_out, instr_type, load_type, sign_extend, rs1, rs2, rd, ia_plus4, alu_output} !==
                    {1'b1, 1'b0, 1'b0, 8'(1 << cls), f3, ~f3[2], r1, r2, rdv, ia, addr}) begin
                    tests_failed++;
                    $display("FAIL rand_single %0d: wb=%b req=%b stall=%b it=%h lt=%b rd=%0d alu=%h, expected wb=1 it=%h lt=%b rd=%0d alu=%h",
                             n, wb_valid, mem_req, stall_out, instr_type, load_type, rd, alu_output,
                             8'(1 << cls), f3, rdv, addr);
                end
`ifdef STAGE4_MISALIGN_TRAP_EN
                tests_run++;
                if (misaligned !== trap) begin
                    tests_failed++;
                    $display("FAIL rand_misaligned %0d: got %b expected %b", n, misaligned, trap);
                end
`endif
            end else begin
                delay   = $urandom_range(0, 3);
                kill    = ($urandom_range(0, 3) == 0);
                kill_at = $urandom_range(0, delay);
                rdata   = '0;
                for (int c = 0; c <= delay; c++) begin
                    tests_run++;
                    if ({mem_req, mem_we, mem_addr, mem_be, is_store ? mem_wdata : 32'h0, stall_out, wb_valid} !==
                        {1'b1, is_store, addr & ~32'h3, model_be(f3, addr, is_store),
                         is_store ? model_wdata(f3, data) : 32'h0, 1'b1, 1'b0}) begin
                        tests_failed++;
                        $display("FAIL rand_req %0d c%0d: req=%b we=%b addr=%h be=%b wdata=%h stall=%b wb=%b, expected we=%b addr=%h be=%b wdata=%h",
                                 n, c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall_out, wb_valid,
                                 is_store, addr & ~32'h3, model_be(f3, addr, is_store), model_wdata(f3, data));
                    end
                    scramble();
                    in_flush  = kill && (c == kill_at);
                    mem_ready = (c == delay);
                    mem_rdata = $urandom;
                    if (c == delay) rdata = mem_rdata;
                    step();
                end
                in_valid  = 1'b0;
                in_flush  = 1'b0;
                mem_ready = 1'b0;
                tests_run++;
                if ({wb_valid, mem_req, stall_out, instr_type, load_type, sign_extend, rs1, rs2, rd, ia_plus4, alu_output} !==
                    {!kill, 1'b0, 1'b0, 8'(1 << cls), f3, ~f3[2], r1, r2, rdv, ia, addr}) begin
                    tests_failed++;
                    $display("FAIL rand_done %0d: wb=%b req=%b stall=%b it=%h lt=%b rd=%0d alu=%h, expected wb=%b it=%h lt=%b rd=%0d alu=%h",
                             n, wb_valid, mem_req, stall_out, instr_type, load_type, rd, alu_output,
                             !kill, 8'(1 << cls), f3, rdv, addr);
                end
                if (is_load && !kill) begin
                    tests_run++;
                    if (memory_read_value !== rdata) begin
                        tests_failed++;
                        $display("FAIL rand_rdata %0d: got %h expected %h", n, memory_read_value, rdata);
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load_delayed();
        test_store_byte();
        test_flush();
        test_reset_during_access();
        test_misaligned_word();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stage4_memory_access.md
# stage4_memory_access

Memory-access stage of the 7-stage RISC-V pipeline, sitting directly upstream of the writeback/register-read stage. It accepts one execute-stage result per cycle and issues loads and stores to data memory over a req/ready handshake. It forwards the raw memory word plus all writeback controls through a pipeline register, and stalls upstream while a memory access is outstanding.

## Interface
- No parameters. Widths come from the codebase types: `word` is 32 bits, `tag` is 5 bits, and `instr_type` spans `range_instrs.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  pipeline clock; all state updates on its rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_flush  in  1  kill: the incoming instruction and any pending load result
- in_instr_type  in  `range_instrs  decoded one-hot class (`do_load, `do_store, `do_branch, `do_jal, `do_jalr, …)
- in_funct3  in  3  load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_rs1, in_rs2, in_rd  in  tag  register tags
- in_alu_output  in  word  effective address, or ALU result for non-memory instructions
- in_store_data  in  word  rs2 value for stores
- in_ia_plus4  in  word  return address
- stall_out  out  1  upstream must hold its inputs
- mem_req  out  1  memory request
- mem_we  out  1  write request
- mem_addr  out  word  word-aligned address ({addr[31:2], 2'b00})
- mem_wdata  out  word  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  request accepted; for reads, mem_rdata is valid in the same cycle
- mem_rdata  in  word  read data
- wb_valid  out  1  drives stage5 is_writeback_stage
- instr_type, load_type, sign_extend, rs1, rs2, rd, ia_plus4, alu_output, memory_read_value  out  registered stage5 inputs
- misaligned  out  1  registered fault flag; only exists with the macro

## Operation
- FSM states: IDLE and ACCESS.
- In IDLE, when in_valid=1 and in_flush=0 the instruction is accepted into the pipeline register.
  - Non-memory instruction: the register loads, wb_valid=1 in the next cycle, and the FSM stays in IDLE.
  - Load or store: the register loads with wb_valid held at 0, the FSM moves to ACCESS, and mem_req/mem_we/mem_addr/mem_be/mem_wdata are registered.
- In ACCESS:
  - mem_req stays at 1 and its payload is stable until a cycle with mem_ready=1.
  - On that edge a load captures mem_rdata into memory_read_value.
  - wb_valid becomes 1 for the next cycle, unless a kill was recorded.
  - The FSM returns to IDLE.
- stall_out = (state==ACCESS), combinational. in_* are ignored while in ACCESS.
- sign_extend = ~in_funct3[2], registered. load_type = in_funct3, registered.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
  - Loads use be = 4'b1111 and mem_we = 0.
- Stores and branches still pass to stage5 with wb_valid=1; stage5 suppresses the rd write itself.
- Flush:
  - in_flush in IDLE: the input is treated as a bubble.
  - in_flush in ACCESS: the access still completes (a store is not cancelled), but wb_valid stays 0 at completion. A "killed" bit holds this until completion.
- Reset: state=IDLE, and every output is 0 (mem_req, mem_we, mem_be, wb_valid, stall_out, all datapath registers, misaligned).
- Reset during ACCESS: the request is dropped immediately and no writeback occurs.

## Timing
- Non-memory latency: accepted at edge N, visible to stage5 in cycle N+1.
- Memory latency: accepted at edge N, mem_req=1 from cycle N+1. If mem_ready=1 in cycle N+k, wb_valid=1 in cycle N+k+1 and stall_out falls in cycle N+k+1.
- Minimum memory latency is 2 cycles. Back-to-back memory ops leave one bubble between them.
- wb_valid is a single-cycle pulse per instruction.
- mem_ready outside ACCESS is ignored.

## Configuration
- STAGE4_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, issues no memory request.
  - The instruction passes in one cycle with wb_valid=1 and misaligned=1; stage5 treats it as a non-writing fault.
- Not defined:
  - The misaligned port is absent.
  - Low address bits are forced to alignment (halfword: addr[0]=0; word: addr[1:0]=0) before lane and byte-enable generation.
  - The access proceeds normally.

## Test plan
- ADD, alu_output=0x0000_1234, rd=5 -> next cycle: wb_valid=1, alu_output=0x1234, rd=5, mem_req=0, stall_out=0.
- LW at 0x100, mem_ready delayed 3 cycles, mem_rdata=0xDEADBEEF:
  - mem_req=1, mem_addr=0x100, be=4'b1111 for 3 cycles with stall_out=1.
  - Then wb_valid=1 with memory_read_value=0xDEADBEEF and sign_extend=1.
- SB at 0x203 with data 0x000000A5 -> mem_we=1, be=4'b1000, wdata=0xA5A5A5A5; wb_valid=1 one cycle after mem_ready.
- LHU at 0x102 with in_flush pulsed during ACCESS -> access completes, wb_valid stays 0, FSM returns to IDLE, and the next ADD writes back normally.
- reset_n asserted during ACCESS -> in the same cycle mem_req=0, stall_out=0, wb_valid=0; after release, an ADD completes in 1 cycle.
- LW at 0x102:
  - With STAGE4_MISALIGN_TRAP_EN: mem_req stays 0, and next cycle wb_valid=1 with misaligned=1.
  - Without it: mem_addr=0x100.
